// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the four-bank main memory port, with read-return routing.
// Define MEM_PORT_ARB_FIXED_PRIO_EN to give requester 1 fixed priority instead of round-robin.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rq0_rd,
  input  logic        rq0_wr,
  input  logic [15:0] rq0_addr,
  input  logic [15:0] rq0_data,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [15:0] rdata0,
  output logic        err0,
  input  logic        rq1_rd,
  input  logic        rq1_wr,
  input  logic [15:0] rq1_addr,
  input  logic [15:0] rq1_data,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [15:0] rdata1,
  output logic        err1,
  output logic [15:0] m_addr,
  output logic [15:0] m_data_in,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [15:0] m_data_out,
  input  logic [3:0]  m_busy,
  input  logic        m_err
);

  // Handshake: rqN_rd/rqN_wr are level requests held until gntN; gntN is
  // asserted combinationally in the cycle the access is placed on the memory.

  logic [1:0]         bank0, bank1;
  logic               ill0, ill1;
  logic               elig0, elig1;
  logic               pick0, pick1;
  logic               rd_issue;
  logic               ret_vld, ret_own;
  logic [MEM_LAT-1:0] pipe_vld, pipe_own;

  assign bank0 = rq0_addr[2:1];
  assign bank1 = rq1_addr[2:1];
  assign ill0  = rq0_rd & rq0_wr;
  assign ill1  = rq1_rd & rq1_wr;
  assign elig0 = ~rst & (rq0_rd ^ rq0_wr) & ~m_busy[bank0];
  assign elig1 = ~rst & (rq1_rd ^ rq1_wr) & ~m_busy[bank1];

`ifdef MEM_PORT_ARB_FIXED_PRIO_EN
  assign pick1 = elig1;
`else
  logic last_gnt;

  // On a tie the requester that did not win last time goes first.
  assign pick1 = elig1 & (~elig0 | ~last_gnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (pick0 | pick1) begin
      last_gnt <= pick1;
    end
  end
`endif

  assign pick0 = elig0 & ~pick1;
  assign gnt0  = pick0;
  assign gnt1  = pick1;

  always_comb begin
    m_rd      = 1'b0;
    m_wr      = 1'b0;
    m_addr    = '0;
    m_data_in = '0;
    if (pick0) begin
      m_rd      = rq0_rd;
      m_wr      = rq0_wr;
      m_addr    = rq0_addr;
      m_data_in = rq0_data;
    end else if (pick1) begin
      m_rd      = rq1_rd;
      m_wr      = rq1_wr;
      m_addr    = rq1_addr;
      m_data_in = rq1_data;
    end
  end

  assign rd_issue = (pick0 & rq0_rd) | (pick1 & rq1_rd);

  // Final stage lines up with m_data_out exactly MEM_LAT cycles after issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      pipe_own <= '0;
    end else begin
      pipe_vld[0] <= rd_issue;
      pipe_own[0] <= pick1;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_own[i] <= pipe_own[i-1];
      end
    end
  end

  assign ret_vld = pipe_vld[MEM_LAT-1] & ~rst;
  assign ret_own = pipe_own[MEM_LAT-1];
  assign rvalid0 = ret_vld & ~ret_own;
  assign rvalid1 = ret_vld & ret_own;
  assign rdata0  = rvalid0 ? m_data_out : '0;
  assign rdata1  = rvalid1 ? m_data_out : '0;

  assign err0 = ~rst & (ill0 | (pick0 & m_err));
  assign err1 = ~rst & (ill1 | (pick1 & m_err));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle-by-cycle vector table plus tie and reset sequences.
module tb_mem_port_arbiter;

  typedef struct {
    logic        rd0, wr0;
    logic [15:0] a0, d0;
    logic        rd1, wr1;
    logic [15:0] a1, d1;
    logic [3:0]  busy;
    logic        merr;
    logic [15:0] mdo;
  } in_t;

  typedef struct {
    logic        g0, g1, e0, e1, mrd, mwr;
    logic [15:0] maddr, mdin;
    logic        rv0, rv1;
    logic [15:0] rdat0, rdat1;
  } exp_t;

`ifdef MEM_PORT_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rq0_rd, rq0_wr, rq1_rd, rq1_wr;
  logic [15:0] rq0_addr, rq0_data, rq1_addr, rq1_data;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [15:0] rdata0, rdata1;
  logic [15:0] m_addr, m_data_in, m_data_out;
  logic        m_rd, m_wr, m_err;
  logic [3:0]  m_busy;

  int total = 0;
  int bad   = 0;

  in_t  in_tab[11];
  exp_t exp_tab[11];

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .rq0_rd(rq0_rd), .rq0_wr(rq0_wr), .rq0_addr(rq0_addr), .rq0_data(rq0_data),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
    .rq1_rd(rq1_rd), .rq1_wr(rq1_wr), .rq1_addr(rq1_addr), .rq1_data(rq1_data),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_rd(m_rd), .m_wr(m_wr),
    .m_data_out(m_data_out), .m_busy(m_busy), .m_err(m_err)
  );

  function automatic in_t idle_in(logic [15:0] mdo);
    in_t v;
    v = '{0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 4'h0, 0, 16'h0};
    v.mdo = mdo;
    return v;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e = '{0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0};
    return e;
  endfunction

  task automatic drive(input in_t v);
    rq0_rd = v.rd0; rq0_wr = v.wr0; rq0_addr = v.a0; rq0_data = v.d0;
    rq1_rd = v.rd1; rq1_wr = v.wr1; rq1_addr = v.a1; rq1_data = v.d1;
    m_busy = v.busy; m_err = v.merr; m_data_out = v.mdo;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    chk({tag, ".gnt0"},      {15'h0, gnt0},    {15'h0, e.g0});
    chk({tag, ".gnt1"},      {15'h0, gnt1},    {15'h0, e.g1});
    chk({tag, ".err0"},      {15'h0, err0},    {15'h0, e.e0});
    chk({tag, ".err1"},      {15'h0, err1},    {15'h0, e.e1});
    chk({tag, ".m_rd"},      {15'h0, m_rd},    {15'h0, e.mrd});
    chk({tag, ".m_wr"},      {15'h0, m_wr},    {15'h0, e.mwr});
    chk({tag, ".m_addr"},    m_addr,           e.maddr);
    chk({tag, ".m_data_in"}, m_data_in,        e.mdin);
    chk({tag, ".rvalid0"},   {15'h0, rvalid0}, {15'h0, e.rv0});
    chk({tag, ".rvalid1"},   {15'h0, rvalid1}, {15'h0, e.rv1});
    chk({tag, ".rdata0"},    rdata0,           e.rdat0);
    chk({tag, ".rdata1"},    rdata1,           e.rdat1);
  endtask

  // Drive just after the rising edge, check at the falling edge, then advance.
  task automatic cycle(input string tag, input in_t v, input exp_t e);
    drive(v);
    @(negedge clk);
    check_outs(tag, e);
    @(posedge clk);
    #1;
  endtask

  // Both requesters read; the winner drops its request once granted.
  task automatic tie_seq(input string tag);
    in_t  v;
    exp_t e;
    logic first;
    first = FIXED;
    v = idle_in(16'h0);
    v.rd0 = 1; v.a0 = 16'h0002; v.rd1 = 1; v.a1 = 16'h0004;
    e = zero_exp();
    e.g0 = ~first; e.g1 = first; e.mrd = 1;
    e.maddr = first ? 16'h0004 : 16'h0002;
    cycle({tag, ".c0"}, v, e);
    if (first) v.rd1 = 0; else v.rd0 = 0;
    e = zero_exp();
    e.g0 = first; e.g1 = ~first; e.mrd = 1;
    e.maddr = first ? 16'h0002 : 16'h0004;
    cycle({tag, ".c1"}, v, e);
    e = zero_exp();
    e.rv0 = ~first; e.rv1 = first;
    e.rdat0 = first ? 16'h0 : 16'hA0A0;
    e.rdat1 = first ? 16'hA0A0 : 16'h0;
    cycle({tag, ".c2"}, idle_in(16'hA0A0), e);
    e = zero_exp();
    e.rv0 = first; e.rv1 = ~first;
    e.rdat0 = first ? 16'hB0B0 : 16'h0;
    e.rdat1 = first ? 16'h0 : 16'hB0B0;
    cycle({tag, ".c3"}, idle_in(16'hB0B0), e);
  endtask

  initial begin
    in_t  v;
    exp_t e;

    // Single read, conflict, write, error cases, in issue order.
    in_tab[0]  = '{1, 0, 16'h0010, 16'h0,    0, 0, 16'h0,    16'h0,    4'h0,    0, 16'h0};
    exp_tab[0] = '{1, 0, 0, 0, 1, 0, 16'h0010, 16'h0,    0, 0, 16'h0,    16'h0};
    in_tab[1]  = idle_in(16'h1234);
    exp_tab[1] = zero_exp();
    in_tab[2]  = idle_in(16'h1234);
    exp_tab[2] = '{0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    1, 0, 16'h1234, 16'h0};
    in_tab[3]  = '{1, 0, 16'h0002, 16'h0,    1, 0, 16'h0004, 16'h0,    4'b0010, 0, 16'h0};
    exp_tab[3] = '{0, 1, 0, 0, 1, 0, 16'h0004, 16'h0,    0, 0, 16'h0,    16'h0};
    in_tab[4]  = '{1, 0, 16'h0002, 16'h0,    0, 0, 16'h0,    16'h0,    4'h0,    0, 16'h0};
    exp_tab[4] = '{1, 0, 0, 0, 1, 0, 16'h0002, 16'h0,    0, 0, 16'h0,    16'h0};
    in_tab[5]  = '{0, 0, 16'h0,    16'h0,    0, 1, 16'h00F0, 16'hBEEF, 4'h0,    0, 16'h5555};
    exp_tab[5] = '{0, 1, 0, 0, 0, 1, 16'h00F0, 16'hBEEF, 0, 1, 16'h0,    16'h5555};
    in_tab[6]  = '{1, 1, 16'h0010, 16'h1111, 0, 0, 16'h0,    16'h0,    4'h0,    0, 16'h6666};
    exp_tab[6] = '{0, 0, 1, 0, 0, 0, 16'h0,    16'h0,    1, 0, 16'h6666, 16'h0};
    in_tab[7]  = '{1, 1, 16'h0010, 16'h1111, 1, 0, 16'h0008, 16'h0,    4'h0,    1, 16'h7777};
    exp_tab[7] = '{0, 1, 1, 1, 1, 0, 16'h0008, 16'h0,    0, 0, 16'h0,    16'h0};
    in_tab[8]  = idle_in(16'h8888);
    in_tab[8].merr = 1;
    exp_tab[8] = zero_exp();
    in_tab[9]  = idle_in(16'h9999);
    exp_tab[9] = '{0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    0, 1, 16'h0,    16'h9999};
    in_tab[10] = idle_in(16'hAAAA);
    exp_tab[10] = zero_exp();

    // Outputs must stay 0 under reset even with a live request present.
    rst = 1;
    v = idle_in(16'h4321);
    v.rd0 = 1; v.a0 = 16'h0010;
    drive(v);
    #2;
    check_outs("reset", zero_exp());
    @(posedge clk);
    #1;
    rst = 0;

    for (int i = 0; i < 11; i++) begin
      cycle($sformatf("vec%0d", i), in_tab[i], exp_tab[i]);
    end

    tie_seq("tie");

    // Read for requester 0 in flight when reset strikes.
    v = idle_in(16'h0);
    v.rd0 = 1; v.a0 = 16'h0010;
    e = zero_exp();
    e.g0 = 1; e.mrd = 1; e.maddr = 16'h0010;
    cycle("rmf.issue", v, e);
    rst = 1;
    v = idle_in(16'hFFFF);
    v.rd0 = 1; v.wr0 = 1; v.rd1 = 1; v.a1 = 16'h0004; v.merr = 1;
    drive(v);
    #1;
    check_outs("rmf.in_rst", zero_exp());
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      cycle($sformatf("rmf.post%0d", i), idle_in(16'hC0C0), zero_exp());
    end
    tie_seq("rmf.tie");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
